// File: rtl/imem_loader.sv
// Boot-time loader: packs a little-endian byte stream into 32-bit words, writes them
// to consecutive instruction memory addresses and holds the core until the load is done.
module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32,
    parameter int WORD_W = 32
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        checksum
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [1:0]        byte_idx;
    logic [ADDR_W-1:0] last_addr;
    logic              count_bad;
    logic              accept;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    always_comb begin
        count_bad = (word_count == '0) || (word_count > DEPTH_C);
        accept    = byte_valid && byte_ready;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= S_IDLE;
            cpu_hold   <= 1'b1;
            byte_ready <= 1'b0;
            imem_wren  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            checksum   <= '0;
            byte_idx   <= '0;
            last_addr  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        if (count_bad) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state      <= S_RECV;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                            imem_addr  <= '0;
                            imem_wdata <= '0;
                            checksum   <= '0;
                            byte_idx   <= '0;
                            // word_count of DEPTH truncates to 0, so 0-1 wraps to DEPTH-1
                            last_addr  <= word_count[ADDR_W-1:0] - 1'b1;
                        end
                    end
                end

                S_RECV: begin
                    if (accept) begin
                        imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
                        checksum <= csum_add(checksum, byte_data);
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            imem_wren  <= 1'b1;
                        end
                    end
                end

                S_WRITE: begin
                    imem_wren <= 1'b0;
                    if (imem_addr == last_addr) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state      <= S_RECV;
                        imem_addr  <= imem_addr + 1'b1;
                        byte_idx   <= '0;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    imem_wren  <= 1'b0;
                    busy       <= 1'b0;
                    cpu_hold   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus
// and popped by a monitor whenever imem_wren is seen.
module tb_imem_loader;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_wren;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  checksum;

    always #5 CLOCK_50 = ~CLOCK_50;

    imem_loader dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_wren  (imem_wren),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .checksum   (checksum)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] cnt);
        word_count = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLOCK_50);
            if (byte_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge CLOCK_50);
        #1;
        byte_valid = 1'b0;
        if (!got) begin
            n_checks++;
            $display("FAIL byte_accept: byte 0x%0h never accepted, want byte_ready=1", b);
        end
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 400; k++) begin
            if (done) break;
            @(negedge CLOCK_50);
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge CLOCK_50);
            if (imem_wren === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %0d data 0x%0h, want no write",
                             imem_addr, imem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_wdata, e.data);
                    check("wr_ready_low", byte_ready, 0);
                    check("wr_hold", cpu_hold, 1);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [31:0] w;

        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        fork
            monitor();
        join_none

        repeat (2) tick();
        check("rst_hold", cpu_hold, 1);
        check("rst_ready", byte_ready, 0);
        check("rst_wren", imem_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_csum", checksum, 0);
        reset = 1'b0;
        tick();

        // two-word program
        exp_q.push_back('{addr: 5'd0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 5'd1, data: 32'h0010_0093});
        pulse_start(6'd2);
        check("t1_busy", busy, 1);
        check("t1_hold", cpu_hold, 1);
        send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        wait_done("t1");
        check("t1_hold_rel", cpu_hold, 0);
        check("t1_busy_end", busy, 0);
        check("t1_csum", checksum, 8'hB6);
        check("t1_addr", imem_addr, 1);
        check("t1_q", exp_q.size(), 0);

        // zero count is rejected, bytes ignored
        pulse_start(6'd0);
        check("t2_error", error, 1);
        check("t2_hold", cpu_hold, 1);
        check("t2_done", done, 0);
        check("t2_ready", byte_ready, 0);
        byte_valid = 1'b1;
        byte_data = 8'h55;
        repeat (3) tick();
        check("t2_ready_late", byte_ready, 0);
        check("t2_busy", busy, 0);
        byte_valid = 1'b0;

        // over-depth count, then single all-ones word
        pulse_start(6'd33);
        check("t3_error", error, 1);
        check("t3_hold", cpu_hold, 1);
        exp_q.push_back('{addr: 5'd0, data: 32'hFFFF_FFFF});
        pulse_start(6'd1);
        check("t3_error_clr", error, 0);
        repeat (4) send_byte(8'hFF);
        wait_done("t3");
        check("t3_csum", checksum, 8'hFC);
        check("t3_q", exp_q.size(), 0);

        // full 32-word load with random valid gaps
        sum = '0;
        for (int i = 0; i < 32; i++) begin
            w = '0;
            for (int j = 0; j < 4; j++) begin
                b = 8'((i * 4 + j) * 37 + 5);
                w[8*j +: 8] = b;
            end
            exp_q.push_back('{addr: 5'(i), data: w});
        end
        pulse_start(6'd32);
        for (int i = 0; i < 128; i++) begin
            b = 8'(i * 37 + 5);
            sum = sum + b;
            repeat ($urandom_range(0, 3)) tick();
            send_byte(b);
        end
        wait_done("t4");
        check("t4_csum", checksum, sum);
        check("t4_addr", imem_addr, 31);
        check("t4_q", exp_q.size(), 0);

        // reset in the middle of the second word
        exp_q.push_back('{addr: 5'd0, data: 32'h0403_0201});
        pulse_start(6'd4);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'h04); send_byte(8'h05); send_byte(8'h06);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_hold", cpu_hold, 1);
        check("t5_busy", busy, 0);
        check("t5_ready", byte_ready, 0);
        check("t5_done", done, 0);
        check("t5_csum_rst", checksum, 0);
        check("t5_q", exp_q.size(), 0);
        repeat (3) tick();
        exp_q.push_back('{addr: 5'd0, data: 32'h4030_2010});
        pulse_start(6'd1);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
        wait_done("t5");
        check("t5_csum", checksum, 8'hA0);
        check("t5_addr", imem_addr, 0);
        check("t5_q2", exp_q.size(), 0);

        // start during RECV ignored, valid held across WRITE
        exp_q.push_back('{addr: 5'd0, data: 32'h4433_2211});
        exp_q.push_back('{addr: 5'd1, data: 32'h8877_6655});
        pulse_start(6'd2);
        send_byte(8'h11); send_byte(8'h22);
        pulse_start(6'd0);
        check("t6_busy", busy, 1);
        check("t6_error", error, 0);
        check("t6_ready", byte_ready, 1);
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        wait_done("t6");
        check("t6_csum", checksum, 8'h64);
        check("t6_addr", imem_addr, 1);
        repeat (3) tick();
        check("final_q", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
